// File: rtl/sm4_round_engine.sv
// Iterative SM4 round datapath placed after key expansion: applies the 32 pre-ordered
// round keys to one 128-bit block per request, ROUNDS_PER_CYCLE rounds per clock.
module sm4_round_engine #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          sm4_enable_in,
    input  logic          key_exp_finished_in,
    input  logic [1023:0] rk_bus_in,
    input  logic [127:0]  data_in,
    input  logic          data_valid_in,
    output logic          data_ready_out,
    output logic [127:0]  result_out,
    output logic          result_valid_out,
    input  logic          result_ready_in,
    output logic          busy_out,
    output logic          abort_out
);

    generate
        if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 && ROUNDS_PER_CYCLE != 4) begin : g_bad_rounds
            $error("sm4_round_engine: ROUNDS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    localparam logic [4:0] LAST_CNT = 5'(32 - ROUNDS_PER_CYCLE);
    localparam logic [4:0] CNT_STEP = 5'(ROUNDS_PER_CYCLE);

    // GB/T 32907 S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    function automatic logic [7:0] sbox_lookup(input logic [7:0] v);
        logic [10:0] idx;
        idx = {~v, 3'b000};
        return SBOX[idx +: 8];
    endfunction

    function automatic logic [31:0] sm4_t(input logic [31:0] a);
        logic [31:0] b;
        b = {sbox_lookup(a[31:24]), sbox_lookup(a[23:16]), sbox_lookup(a[15:8]), sbox_lookup(a[7:0])};
        return b ^ {b[29:0], b[31:30]} ^ {b[21:0], b[31:22]} ^ {b[13:0], b[31:14]} ^ {b[7:0], b[31:8]};
    endfunction

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic [4:0]    r_cnt;
    logic [31:0]   r_x0, r_x1, r_x2, r_x3;
    logic [127:0]  r_result;
    logic          r_valid;
    logic          r_abort;
    logic          w_accept, w_step, w_finish, w_abort;
    logic [31:0]   w_x0, w_x1, w_x2, w_x3, w_xnew;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // ready never depends on valid, and a raised result_valid_out holds until accepted.
    assign data_ready_out   = (r_state == S_IDLE) && sm4_enable_in && key_exp_finished_in;
    assign result_out       = r_result;
    assign result_valid_out = r_valid;
    assign busy_out         = (r_state != S_IDLE);
    assign abort_out        = r_abort;

    always_comb begin
        w_x0   = r_x0;
        w_x1   = r_x1;
        w_x2   = r_x2;
        w_x3   = r_x3;
        w_xnew = '0;
        for (int j = 0; j < ROUNDS_PER_CYCLE; j++) begin
            w_xnew = w_x0 ^ sm4_t(w_x1 ^ w_x2 ^ w_x3 ^ rk_bus_in[32*(int'(r_cnt) + j) +: 32]);
            w_x0   = w_x1;
            w_x1   = w_x2;
            w_x2   = w_x3;
            w_x3   = w_xnew;
        end
    end

    // Disable beats key loss, which beats normal sequencing.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_step       = 1'b0;
        w_finish     = 1'b0;
        w_abort      = 1'b0;
        if (!sm4_enable_in) begin
            w_next_state = S_IDLE;
            w_abort      = (r_state != S_IDLE);
        end else if (r_state == S_ROUND && !key_exp_finished_in) begin
            w_next_state = S_IDLE;
            w_abort      = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (data_valid_in && data_ready_out) begin
                        w_accept     = 1'b1;
                        w_next_state = S_ROUND;
                    end
                end
                S_ROUND: begin
                    w_step = 1'b1;
                    if (r_cnt == LAST_CNT) begin
                        w_finish     = 1'b1;
                        w_next_state = S_DONE;
                    end
                end
                S_DONE: begin
                    if (r_valid && result_ready_in) begin
                        w_next_state = S_IDLE;
                    end
                end
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_x0     <= '0;
            r_x1     <= '0;
            r_x2     <= '0;
            r_x3     <= '0;
            r_result <= '0;
            r_valid  <= 1'b0;
            r_abort  <= 1'b0;
        end else begin
            r_abort <= w_abort;
            r_valid <= (w_next_state == S_DONE);
            r_cnt   <= (w_step && !w_finish) ? r_cnt + CNT_STEP : 5'd0;
            if (w_accept) begin
                r_x0 <= data_in[127:96];
                r_x1 <= data_in[95:64];
                r_x2 <= data_in[63:32];
                r_x3 <= data_in[31:0];
            end else if (w_step) begin
                r_x0 <= w_x0;
                r_x1 <= w_x1;
                r_x2 <= w_x2;
                r_x3 <= w_x3;
            end
            // Output word order is reversed: the newest word lands in the top 32 bits.
            if (w_finish) begin
                r_result <= {w_x3, w_x2, w_x1, w_x0};
            end
        end
    end

endmodule

// File: tb/tb_sm4_round_engine.sv
// Bench for sm4_round_engine: transaction-level SM4 model with per-cycle output compare,
// directed vectors and handshake corner cases, random blocks, and a rounds-per-cycle sweep.
module tb_sm4_round_engine;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          en = 1'b1;
    logic          kf = 1'b1;
    logic [1023:0] rk_bus = '0;
    logic [127:0]  din = '0;
    logic          dv = 1'b0;
    logic          rr = 1'b1;
    logic          dv2 = 1'b0, rr2 = 1'b0, dv4 = 1'b0, rr4 = 1'b0;

    logic          data_ready_out, result_valid_out, busy_out, abort_out;
    logic [127:0]  result_out;
    logic          dr2, rv2, busy2, abort2, dr4, rv4, busy4, abort4;
    logic [127:0]  res2, res4;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [127:0] STD_PT = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] STD_CT = 128'h681edf34d206965e86b3e94f536e4246;

    localparam logic [2047:0] SBOX_TAB = {
        128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    always #5 clk = ~clk;

    sm4_round_engine #(.ROUNDS_PER_CYCLE(1)) u_dut (
        .clk(clk), .reset(reset), .sm4_enable_in(en), .key_exp_finished_in(kf),
        .rk_bus_in(rk_bus), .data_in(din), .data_valid_in(dv), .data_ready_out(data_ready_out),
        .result_out(result_out), .result_valid_out(result_valid_out), .result_ready_in(rr),
        .busy_out(busy_out), .abort_out(abort_out)
    );

    sm4_round_engine #(.ROUNDS_PER_CYCLE(2)) u_dut_r2 (
        .clk(clk), .reset(reset), .sm4_enable_in(en), .key_exp_finished_in(kf),
        .rk_bus_in(rk_bus), .data_in(din), .data_valid_in(dv2), .data_ready_out(dr2),
        .result_out(res2), .result_valid_out(rv2), .result_ready_in(rr2),
        .busy_out(busy2), .abort_out(abort2)
    );

    sm4_round_engine #(.ROUNDS_PER_CYCLE(4)) u_dut_r4 (
        .clk(clk), .reset(reset), .sm4_enable_in(en), .key_exp_finished_in(kf),
        .rk_bus_in(rk_bus), .data_in(din), .data_valid_in(dv4), .data_ready_out(dr4),
        .result_out(res4), .result_valid_out(rv4), .result_ready_in(rr4),
        .busy_out(busy4), .abort_out(abort4)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference arithmetic ----------------
    function automatic logic [7:0] sbox(input logic [7:0] v);
        logic [2047:0] t;
        t = SBOX_TAB;
        return t[8*(255 - int'(v)) +: 8];
    endfunction

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] tau(input logic [31:0] a);
        return {sbox(a[31:24]), sbox(a[23:16]), sbox(a[15:8]), sbox(a[7:0])};
    endfunction

    function automatic logic [31:0] t_enc(input logic [31:0] a);
        logic [31:0] b;
        b = tau(a);
        return b ^ rotl(b, 2) ^ rotl(b, 10) ^ rotl(b, 18) ^ rotl(b, 24);
    endfunction

    function automatic logic [31:0] t_key(input logic [31:0] a);
        logic [31:0] b;
        b = tau(a);
        return b ^ rotl(b, 13) ^ rotl(b, 23);
    endfunction

    function automatic logic [1023:0] key_expand(input logic [127:0] mk);
        logic [31:0]   k [0:35];
        logic [31:0]   ck;
        logic [127:0]  fk;
        logic [1023:0] bus;
        fk = 128'ha3b1bac656aa3350677d9197b27022dc;
        bus = '0;
        for (int i = 0; i < 4; i++) k[i] = mk[127-32*i -: 32] ^ fk[127-32*i -: 32];
        for (int i = 0; i < 32; i++) begin
            for (int j = 0; j < 4; j++) ck[31-8*j -: 8] = 8'((4*i + j) * 7);
            k[i+4] = k[i] ^ t_key(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck);
            bus[32*i +: 32] = k[i+4];
        end
        return bus;
    endfunction

    function automatic logic [1023:0] reverse_keys(input logic [1023:0] b);
        logic [1023:0] o;
        for (int i = 0; i < 32; i++) o[32*i +: 32] = b[32*(31-i) +: 32];
        return o;
    endfunction

    function automatic logic [127:0] sm4_crypt(input logic [127:0] blk, input logic [1023:0] bus);
        logic [31:0] x [0:35];
        for (int i = 0; i < 4; i++) x[i] = blk[127-32*i -: 32];
        for (int i = 0; i < 32; i++) x[i+4] = x[i] ^ t_enc(x[i+1] ^ x[i+2] ^ x[i+3] ^ bus[32*i +: 32]);
        return {x[35], x[34], x[33], x[32]};
    endfunction

    // ---------------- transaction model of the R=1 instance ----------------
    int           m_state = 0;   // 0 idle, 1 computing, 2 holding result
    int           m_left = 0;
    logic         m_valid = 1'b0;
    logic         m_abort = 1'b0;
    logic [127:0] m_pending = '0;
    logic [127:0] m_res = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_state <= 0;
            m_valid <= 1'b0;
            m_abort <= 1'b0;
            m_left  <= 0;
        end else begin
            m_abort <= 1'b0;
            if (!en) begin
                m_abort <= (m_state != 0);
                m_state <= 0;
                m_valid <= 1'b0;
            end else if (m_state == 1 && !kf) begin
                m_abort <= 1'b1;
                m_state <= 0;
            end else if (m_state == 0) begin
                if (dv && kf) begin
                    m_pending <= sm4_crypt(din, rk_bus);
                    m_left    <= 32;
                    m_state   <= 1;
                end
            end else if (m_state == 1) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_state <= 2;
                    m_valid <= 1'b1;
                    m_res   <= m_pending;
                end
            end else if (rr) begin
                m_valid <= 1'b0;
                m_state <= 0;
            end
        end
    end

    always @(negedge clk) begin
        check("data_ready", data_ready_out, (m_state == 0) && en && kf);
        check("result_valid", result_valid_out, m_valid);
        check("abort", abort_out, m_abort);
        check("busy", busy_out, m_state != 0);
        if (m_valid) check("result", result_out, m_res);
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [127:0] blk);
        int ok;
        ok = 0;
        din = blk;
        dv = 1'b1;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (m_state == 0 && en && kf) begin
                ok = 1;
                break;
            end
        end
        check("send_accept", ok, 1);
        @(posedge clk);
        #1;
        dv = 1'b0;
    endtask

    task automatic wait_result(input int lat, input string name);
        int got;
        got = -1;
        for (int k = 1; k <= lat + 8; k++) begin
            step();
            if (result_valid_out === 1'b1) begin
                got = k;
                break;
            end
        end
        check({name, "_latency"}, got, lat);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1023:0] enc_keys, dec_keys;
        logic [127:0]  blk, blk2;
        int            cnt_abort, cnt_valid, lat2, lat4;

        enc_keys = key_expand(STD_PT);
        dec_keys = reverse_keys(enc_keys);
        check("model_rk0", enc_keys[31:0], 32'hf12186f9);
        check("model_rk31", enc_keys[1023:992], 32'h9124a012);
        check("model_enc", sm4_crypt(STD_PT, enc_keys), STD_CT);
        check("model_dec", sm4_crypt(STD_CT, dec_keys), STD_PT);
        rk_bus = enc_keys;

        #1 reset = 1'b1;
        repeat (3) step();
        check("rst_result", result_out, 128'h0);
        check("rst_valid", result_valid_out, 0);
        check("rst_abort", abort_out, 0);
        check("rst_busy", busy_out, 0);
        reset = 1'b0;
        step();

        // standard encrypt and decrypt vectors
        send(STD_PT);
        wait_result(32, "enc");
        check("enc_result", result_out, STD_CT);
        rk_bus = dec_keys;
        send(STD_CT);
        wait_result(32, "dec");
        check("dec_result", result_out, STD_PT);
        step();

        // backpressure then back-to-back block
        rk_bus = enc_keys;
        rr = 1'b0;
        blk = {$urandom(), $urandom(), $urandom(), $urandom()};
        send(blk);
        wait_result(32, "bp");
        for (int i = 0; i < 20; i++) begin
            step();
            check("bp_hold_result", result_out, sm4_crypt(blk, enc_keys));
            check("bp_hold_valid", result_valid_out, 1);
            check("bp_hold_ready", data_ready_out, 0);
        end
        rr = 1'b1;
        step();
        check("bp_release_valid", result_valid_out, 0);
        check("bp_release_busy", busy_out, 0);
        blk2 = {$urandom(), $urandom(), $urandom(), $urandom()};
        send(blk2);
        wait_result(32, "b2b");
        check("b2b_result", result_out, sm4_crypt(blk2, enc_keys));
        step();

        // key loss at round 10
        send(STD_PT);
        repeat (10) step();
        kf = 1'b0;
        cnt_abort = 0;
        cnt_valid = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (abort_out === 1'b1) cnt_abort++;
            if (result_valid_out === 1'b1) cnt_valid++;
        end
        check("keyloss_abort_pulses", cnt_abort, 1);
        check("keyloss_no_valid", cnt_valid, 0);
        check("keyloss_idle", busy_out, 0);
        kf = 1'b1;
        send(STD_PT);
        wait_result(32, "resend");
        check("resend_result", result_out, STD_CT);
        step();

        // enable drop while holding a result
        rr = 1'b0;
        send(STD_PT);
        wait_result(32, "en_done");
        en = 1'b0;
        step();
        check("en_drop_valid", result_valid_out, 0);
        check("en_drop_abort", abort_out, 1);
        step();
        check("en_drop_abort_once", abort_out, 0);
        en = 1'b1;
        rr = 1'b1;
        step();

        // asynchronous reset at round 5
        send(STD_PT);
        repeat (5) step();
        reset = 1'b1;
        #1;
        check("midrst_result", result_out, 128'h0);
        check("midrst_valid", result_valid_out, 0);
        check("midrst_busy", busy_out, 0);
        check("midrst_abort", abort_out, 0);
        step();
        check("midrst_no_abort", abort_out, 0);
        reset = 1'b0;
        step();

        // random keys, blocks, holds and enable drops
        for (int n = 0; n < 12; n++) begin
            for (int i = 0; i < 32; i++) rk_bus[32*i +: 32] = $urandom();
            blk = {$urandom(), $urandom(), $urandom(), $urandom()};
            if ($urandom_range(0, 3) == 0) begin
                send(blk);
                repeat ($urandom_range(1, 34)) step();
                en = 1'b0;
                step();
                en = 1'b1;
                rr = 1'b1;
                step();
            end else begin
                rr = 1'b0;
                send(blk);
                wait_result(32, "rand");
                check("rand_result", result_out, sm4_crypt(blk, rk_bus));
                repeat ($urandom_range(0, 4)) step();
                rr = 1'b1;
                step();
            end
        end

        // rounds-per-cycle sweep on the extra instances
        for (int v = 0; v < 2; v++) begin
            rk_bus = (v == 0) ? enc_keys : dec_keys;
            din = (v == 0) ? STD_PT : STD_CT;
            dv2 = 1'b1;
            dv4 = 1'b1;
            rr2 = 1'b0;
            rr4 = 1'b0;
            step();
            dv2 = 1'b0;
            dv4 = 1'b0;
            check("sweep_busy2", busy2, 1);
            check("sweep_busy4", busy4, 1);
            lat2 = -1;
            lat4 = -1;
            for (int k = 1; k <= 40; k++) begin
                step();
                if (rv2 === 1'b1 && lat2 < 0) lat2 = k;
                if (rv4 === 1'b1 && lat4 < 0) lat4 = k;
            end
            check("sweep_lat2", lat2, 16);
            check("sweep_lat4", lat4, 8);
            check("sweep_res2", res2, (v == 0) ? STD_CT : STD_PT);
            check("sweep_res4", res4, (v == 0) ? STD_CT : STD_PT);
            check("sweep_ready2", dr2, 0);
            check("sweep_ready4", dr4, 0);
            check("sweep_abort2", abort2, 0);
            check("sweep_abort4", abort4, 0);
            rr2 = 1'b1;
            rr4 = 1'b1;
            step();
            check("sweep_release2", rv2, 0);
            check("sweep_release4", rv4, 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
